// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM states, transaction owner
// and the default data-streak limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int MAX_DSTREAK_DEFAULT = 4;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline fetch/data ports and memory handshake bundled together; the
// arbiter uses the slave view, the pipeline/memory environment the master view.
interface unified_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_flush;
    logic [DW-1:0]   if_rdata;
    logic            if_valid;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_valid;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    logic            stall_if;
    logic            stall_mem;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/unified_mem_arbiter_req_latch.sv
// Holds the selected request's {we, addr, wdata, be} stable from arbitration
// until the memory grants it.
module arb_req_latch #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            next_we,
    input  logic [AW-1:0]   next_addr,
    input  logic [DW-1:0]   next_wdata,
    input  logic [DW/8-1:0] next_be,
    output logic            we,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   wdata,
    output logic [DW/8-1:0] be
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            be    <= '0;
        end else if (load) begin
            we    <= next_we;
            addr  <= next_addr;
            wdata <= next_wdata;
            be    <= next_be;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch and the memory stage, with a bounded data-priority streak.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    unified_mem_arbiter_if.slave bus
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    state_t          state, state_nx;
    owner_t          owner;
    logic            drop;
    logic [SW-1:0]   streak;
    logic            sel_d, sel_i, fire;

    logic            next_we;
    logic [AW-1:0]   next_addr;
    logic [DW-1:0]   next_wdata;
    logic [DW/8-1:0] next_be;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        sel_d    = 1'b0;
        sel_i    = 1'b0;
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.d_req && (streak < STREAK_MAX || !bus.if_req)) begin
                    sel_d    = 1'b1;
                    state_nx = ISSUE;
                end else if (bus.if_req && !bus.if_flush) begin
                    sel_i    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE:     if (bus.mem_gnt)    state_nx = WAIT_RESP;
            WAIT_RESP: if (bus.mem_rvalid) state_nx = IDLE;
            default:                       state_nx = IDLE;
        endcase
    end

    always_comb begin
        next_we    = 1'b0;
        next_addr  = bus.if_addr;
        next_wdata = '0;
        next_be    = '0;
        if (sel_d) begin
            next_we    = bus.d_we;
            next_addr  = bus.d_addr;
            next_wdata = bus.d_wdata;
            next_be    = bus.d_be;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= OWN_I;
            drop   <= 1'b0;
            streak <= '0;
        end else begin
            state <= state_nx;
            if (sel_d)      owner <= OWN_D;
            else if (sel_i) owner <= OWN_I;
            // A redirected fetch still has to drain from memory; only its pulse is hidden.
            if (state_nx == IDLE)
                drop <= 1'b0;
            else if (bus.if_flush && owner == OWN_I && state != IDLE)
                drop <= 1'b1;
            if (!bus.if_req || sel_i)
                streak <= '0;
            else if (sel_d && streak != STREAK_MAX)
                streak <= streak + 1'b1;
        end
    end

    arb_req_latch #(.AW(AW), .DW(DW)) u_req_latch (
        .clk       (clk),
        .reset     (reset),
        .load      (sel_d | sel_i),
        .next_we   (next_we),
        .next_addr (next_addr),
        .next_wdata(next_wdata),
        .next_be   (next_be),
        .we        (bus.mem_we),
        .addr      (bus.mem_addr),
        .wdata     (bus.mem_wdata),
        .be        (bus.mem_be)
    );

    assign fire         = (state == WAIT_RESP) && bus.mem_rvalid;
    assign bus.mem_req  = (state == ISSUE);
    assign bus.if_valid = fire && owner == OWN_I && !drop && !bus.if_flush;
    assign bus.d_valid  = fire && owner == OWN_D;
    assign bus.if_rdata = bus.if_valid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = bus.d_valid  ? bus.mem_rdata : '0;
    assign bus.stall_if  = bus.if_req && !bus.if_valid;
    assign bus.stall_mem = bus.d_req  && !bus.d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scenario tests plus a randomized run against a transaction-level model of
// the arbitration rules and a word-addressed reference memory.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32, DW = 32, MAXS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    unified_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXS)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_arr [256];
    int          gnt_cnt, rsp_cnt;
    bit          req_seen;
    logic [31:0] rsp_data;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rsp_cnt = 0; req_seen = 0; gnt_cnt = 0;
        reset = 1;
        next();
        next();
        reset = 0;
    endtask

    // Behavioural memory: grant after a random wait, respond a random number of cycles later.
    task automatic mem_step(int glo, int ghi, int rlo, int rhi);
        int idx;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = $urandom;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin bus.mem_rvalid = 1; bus.mem_rdata = rsp_data; end
        end else if (bus.mem_req) begin
            if (!req_seen) begin req_seen = 1; gnt_cnt = $urandom_range(ghi, glo); end
            if (gnt_cnt == 0) begin
                bus.mem_gnt = 1; req_seen = 0; rsp_cnt = $urandom_range(rhi, rlo);
                idx = int'(bus.mem_addr[9:2]);
                rsp_data = mem_arr[idx];
                if (bus.mem_we)
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be[b]) mem_arr[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end else begin
                gnt_cnt--;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
             bus.if_valid, bus.d_valid, bus.stall_if, bus.stall_mem} !== '0)
            begin bad++; $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%h ifv=%b dv=%b, want all 0",
                bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_valid, bus.d_valid); end
        next(); bus.mem_rvalid = 1; bus.mem_gnt = 1; bus.mem_rdata = 32'h1234_5678; settle();
        total++;
        if ({bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata} !== '0)
            begin bad++; $display("FAIL stale_rvalid: ifv=%b dv=%b if_rdata=%h d_rdata=%h, want 0",
                bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata); end
        next(); bus.mem_rvalid = 0; bus.mem_gnt = 0; settle();
        total++;
        if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL stale_gnt_idle: mem_req=%b want 0", bus.mem_req); end
    endtask

    task automatic test_lone_fetch();
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h0000_0100; settle();
        total++;
        if ({bus.mem_req, bus.if_valid, bus.stall_if} !== 3'b001)
            begin bad++; $display("FAIL fetch_c0: req/valid/stall=%b want 001", {bus.mem_req, bus.if_valid, bus.stall_if}); end
        next(); bus.mem_gnt = 1; settle();
        total++;
        if ({bus.mem_req, bus.if_valid, bus.stall_if, bus.mem_we, bus.mem_addr} !== {4'b1010, 32'h100})
            begin bad++; $display("FAIL fetch_c1: req/valid/stall/we=%b addr=%h want 1010 100",
                {bus.mem_req, bus.if_valid, bus.stall_if, bus.mem_we}, bus.mem_addr); end
        next(); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0010_0093; settle();
        total++;
        if ({bus.mem_req, bus.if_valid, bus.stall_if, bus.if_rdata} !== {3'b010, 32'h0010_0093})
            begin bad++; $display("FAIL fetch_c2: req/valid/stall=%b rdata=%h want 010 00100093",
                {bus.mem_req, bus.if_valid, bus.stall_if}, bus.if_rdata); end
        next(); bus.if_req = 0; bus.mem_rvalid = 0; settle();
        total++;
        if ({bus.mem_req, bus.if_valid} !== 2'b00)
            begin bad++; $display("FAIL fetch_c3: req/valid=%b want 00", {bus.mem_req, bus.if_valid}); end
    endtask

    task automatic test_priority();
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h104;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; settle();
        next(); bus.mem_gnt = 1; settle();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.stall_if, bus.mem_addr} !== {3'b101, 32'h2000})
            begin bad++; $display("FAIL prio_issue_load: req/we/stall=%b addr=%h want 101 2000",
                {bus.mem_req, bus.mem_we, bus.stall_if}, bus.mem_addr); end
        next(); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE_0001; settle();
        total++;
        if ({bus.d_valid, bus.if_valid, bus.stall_if, bus.stall_mem, bus.d_rdata} !== {4'b1010, 32'hCAFE_0001})
            begin bad++; $display("FAIL prio_load_done: dv/ifv/stall_if/stall_mem=%b d_rdata=%h want 1010 cafe0001",
                {bus.d_valid, bus.if_valid, bus.stall_if, bus.stall_mem}, bus.d_rdata); end
        next(); bus.d_req = 0; bus.mem_rvalid = 0; settle();
        total++;
        if ({bus.mem_req, bus.stall_if} !== 2'b01)
            begin bad++; $display("FAIL prio_gap: req/stall_if=%b want 01", {bus.mem_req, bus.stall_if}); end
        next(); bus.mem_gnt = 1; settle();
        total++;
        if ({bus.mem_req, bus.stall_if, bus.mem_addr} !== {2'b11, 32'h104})
            begin bad++; $display("FAIL prio_fetch_issue: req/stall_if=%b addr=%h want 11 104",
                {bus.mem_req, bus.stall_if}, bus.mem_addr); end
        next(); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0013; settle();
        total++;
        if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'h13})
            begin bad++; $display("FAIL prio_fetch_done: ifv=%b rdata=%h want 1 13", bus.if_valid, bus.if_rdata); end
        next(); idle_inputs(); settle();
    endtask

    task automatic test_streak();
        int seq [10];
        int n, cnt, expd;
        do_reset();
        n = 0;
        bus.if_req = 1; bus.if_addr = 32'h0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000;
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            next();
            mem_step(0, 0, 1, 1);
            settle();
            if (bus.if_valid && n < 10) begin seq[n] = 0; n++; end
            if (bus.d_valid && n < 10)  begin seq[n] = 1; n++; end
        end
        total++;
        if (n != 10) begin bad++; $display("FAIL streak_budget: completions=%0d want 10", n); end
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (cnt < MAXS) begin expd = 1; cnt++; end
            else begin expd = 0; cnt = 0; end
            total++;
            if (seq[k] != expd)
                begin bad++; $display("FAIL streak_order[%0d]: owner=%s want %s", k,
                    seq[k] ? "D" : "I", expd ? "D" : "I"); end
        end
        next(); idle_inputs(); next(); next(); next();
    endtask

    task automatic test_flush();
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h180;
        next(); bus.mem_gnt = 1; settle();
        next(); bus.mem_gnt = 0; bus.if_flush = 1; bus.if_addr = 32'h200; settle();
        total++;
        if ({bus.mem_req, bus.if_valid, bus.stall_if} !== 3'b001)
            begin bad++; $display("FAIL flush_wait: req/valid/stall=%b want 001", {bus.mem_req, bus.if_valid, bus.stall_if}); end
        next(); bus.if_flush = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0BAD_0BAD; settle();
        total++;
        if ({bus.if_valid, bus.stall_if} !== 2'b01)
            begin bad++; $display("FAIL flush_drop: ifv/stall=%b want 01", {bus.if_valid, bus.stall_if}); end
        next(); bus.mem_rvalid = 0; settle();
        next(); bus.mem_gnt = 1; settle();
        total++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h200})
            begin bad++; $display("FAIL flush_refetch: req=%b addr=%h want 1 200", bus.mem_req, bus.mem_addr); end
        next(); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0513; settle();
        total++;
        if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'h513})
            begin bad++; $display("FAIL flush_refetch_done: ifv=%b rdata=%h want 1 513", bus.if_valid, bus.if_rdata); end
        // flush coinciding with the response, then a flush while idle
        next(); bus.mem_rvalid = 0; bus.if_addr = 32'h300;
        next(); bus.mem_gnt = 1;
        next(); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.if_flush = 1; settle();
        total++;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL flush_with_rvalid: ifv=%b want 0", bus.if_valid); end
        next(); bus.mem_rvalid = 0;
        next(); bus.if_flush = 0; settle();
        total++;
        if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL flush_idle_block: mem_req=%b want 0", bus.mem_req); end
        next(); bus.mem_gnt = 1; settle();
        total++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h300})
            begin bad++; $display("FAIL flush_idle_release: req=%b addr=%h want 1 300", bus.mem_req, bus.mem_addr); end
        next(); bus.mem_gnt = 0; bus.mem_rvalid = 1;
        next(); idle_inputs(); settle();
    endtask

    task automatic test_store_gnt_delay();
        do_reset();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h3000; bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
        for (int k = 1; k <= 4; k++) begin
            next(); bus.mem_gnt = (k == 4); settle();
            total++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.stall_mem} !==
                {2'b11, 32'h3000, 32'hDEAD_BEEF, 4'b0011, 1'b1})
                begin bad++; $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wdata=%h be=%b stall=%b want 1 1 3000 deadbeef 0011 1",
                    k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.stall_mem); end
        end
        next(); bus.mem_gnt = 0; bus.mem_rvalid = 1; settle();
        total++;
        if ({bus.mem_req, bus.d_valid, bus.stall_mem} !== 3'b010)
            begin bad++; $display("FAIL store_done: req/dv/stall=%b want 010", {bus.mem_req, bus.d_valid, bus.stall_mem}); end
        next(); idle_inputs(); settle();
        total++;
        if ({bus.mem_req, bus.d_valid} !== 2'b00)
            begin bad++; $display("FAIL store_after: req/dv=%b want 00", {bus.mem_req, bus.d_valid}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h140;
        next(); bus.mem_gnt = 1;
        next(); bus.mem_gnt = 0; bus.if_req = 0; reset = 1; settle();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_valid, bus.d_valid,
             bus.if_rdata, bus.d_rdata, bus.stall_if, bus.stall_mem} !== '0)
            begin bad++; $display("FAIL midreset_outputs: req=%b addr=%h ifv=%b dv=%b, want all 0",
                bus.mem_req, bus.mem_addr, bus.if_valid, bus.d_valid); end
        next(); reset = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h7777_7777; settle();
        total++;
        if ({bus.if_valid, bus.d_valid, bus.if_rdata, bus.mem_req} !== '0)
            begin bad++; $display("FAIL midreset_late_rvalid: ifv=%b dv=%b rdata=%h req=%b want 0",
                bus.if_valid, bus.d_valid, bus.if_rdata, bus.mem_req); end
        next(); bus.mem_rvalid = 0; bus.if_req = 1; bus.if_addr = 32'h144;
        next(); settle();
        total++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h144})
            begin bad++; $display("FAIL midreset_idle: req=%b addr=%h want 1 144", bus.mem_req, bus.mem_addr); end
        next(); bus.mem_gnt = 1;
        next(); bus.mem_gnt = 0; bus.mem_rvalid = 1;
        next(); idle_inputs(); settle();
    endtask

    task automatic test_random();
        bit          f_active, d_active, f_got, d_got;
        bit          prev_if, prev_d, prev_mreq, owner_d, exp_d, first_issue;
        logic [31:0] f_addr, d_addr, d_wdata, wmask;
        logic [3:0]  d_be;
        bit          d_we;
        int          obs, quiet, nf, nd, idx;
        do_reset();
        for (int i = 0; i < 256; i++) begin mem_arr[i] = $urandom; ref_arr[i] = mem_arr[i]; end
        f_active = 0; d_active = 0; f_got = 0; d_got = 0;
        prev_if = 0; prev_d = 0; prev_mreq = 0; obs = 0; quiet = 0; nf = 0; nd = 0;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; d_we = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            next();
            mem_step(0, 2, 1, 3);
            if (f_got) f_active = 0;
            if (d_got) d_active = 0;
            if (!f_active && $urandom_range(2, 0) == 0) begin
                f_active = 1; f_addr = 32'($urandom_range(127, 0)) << 2;
            end
            if (!d_active && $urandom_range(3, 0) != 0) begin
                d_active = 1; d_addr = 32'($urandom_range(255, 128)) << 2;
                d_we = $urandom_range(1, 0) == 1; d_wdata = $urandom; d_be = 4'($urandom_range(15, 0));
            end
            bus.if_req = f_active; bus.if_addr = f_addr;
            bus.d_req = d_active; bus.d_we = d_we; bus.d_addr = d_addr; bus.d_wdata = d_wdata; bus.d_be = d_be;
            settle();

            first_issue = bus.mem_req && !prev_mreq;
            if (first_issue) begin
                owner_d = bus.mem_addr[9];
                exp_d = prev_d && (obs < MAXS || !prev_if);
                total++;
                if (owner_d !== exp_d)
                    begin bad++; $display("FAIL rnd_arb cyc%0d: owner=%s want %s (if=%b d=%b streak=%0d)",
                        cyc, owner_d ? "D" : "I", exp_d ? "D" : "I", prev_if, prev_d, obs); end
                total++;
                if (owner_d ? ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {d_we, d_addr, d_wdata, d_be})
                            : ({bus.mem_we, bus.mem_addr} !== {1'b0, f_addr}))
                    begin bad++; $display("FAIL rnd_fields cyc%0d: we=%b addr=%h wdata=%h be=%b", cyc,
                        bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
            end
            if (!prev_if) obs = 0;
            else if (first_issue) obs = owner_d ? ((obs < MAXS) ? obs + 1 : obs) : 0;

            f_got = bus.if_valid; d_got = bus.d_valid;
            if (bus.if_valid) begin
                nf++;
                idx = int'(f_addr[9:2]);
                total++;
                if (bus.if_rdata !== ref_arr[idx])
                    begin bad++; $display("FAIL rnd_fetch_data cyc%0d: got %h want %h", cyc, bus.if_rdata, ref_arr[idx]); end
            end
            if (bus.d_valid) begin
                nd++;
                idx = int'(d_addr[9:2]);
                if (d_we) begin
                    wmask = {{8{d_be[3]}}, {8{d_be[2]}}, {8{d_be[1]}}, {8{d_be[0]}}};
                    ref_arr[idx] = (ref_arr[idx] & ~wmask) | (d_wdata & wmask);
                end else begin
                    total++;
                    if (bus.d_rdata !== ref_arr[idx])
                        begin bad++; $display("FAIL rnd_load_data cyc%0d: got %h want %h", cyc, bus.d_rdata, ref_arr[idx]); end
                end
            end
            total++;
            if ({bus.stall_if, bus.stall_mem} !== {f_active && !bus.if_valid, d_active && !bus.d_valid})
                begin bad++; $display("FAIL rnd_stall cyc%0d: got %b want %b", cyc, {bus.stall_if, bus.stall_mem},
                    {f_active && !bus.if_valid, d_active && !bus.d_valid}); end
            total++;
            if ({bus.if_valid && !f_active, bus.d_valid && !d_active, bus.if_valid && bus.d_valid} !== 3'b000)
                begin bad++; $display("FAIL rnd_spurious_valid cyc%0d: ifv=%b dv=%b", cyc, bus.if_valid, bus.d_valid); end

            quiet = (bus.if_valid || bus.d_valid || !(f_active || d_active)) ? 0 : quiet + 1;
            if (quiet > 40) begin
                total++; bad++;
                $display("FAIL rnd_timeout cyc%0d: no completion for %0d cycles", cyc, quiet);
                break;
            end
            prev_if = f_active; prev_d = d_active; prev_mreq = bus.mem_req;
        end
        total++;
        if (nf < 10 || nd < 10) begin bad++; $display("FAIL rnd_activity: fetches=%0d data=%0d want >=10 each", nf, nd); end
        next(); idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_lone_fetch();
        test_priority();
        test_streak();
        test_flush();
        test_store_gnt_delay();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (memory-stage) port. Arbitrates at most one outstanding transaction at a time and sequences the request/grant/response handshake with the memory. Returns fetch and load data to the pipeline. Generates the fetch and memory-stage stall signals that the hazard unit ORs into StallF/StallD and into whole-pipeline freeze.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_DSTREAK, 4, max consecutive data grants while a fetch waits (≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid or if_flush
- if_addr  in  AW  fetch address (PCF)
- if_flush  in  1  fetch redirect (PCSrcE); in-flight fetch is discarded
- if_rdata  out  DW  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address (ALUResultM)
- d_wdata  in  DW  store data (WriteDataM)
- d_be  in  DW/8  store byte enables
- d_rdata  out  DW  load data (ReadDataM)
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_req  out  1  memory request
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  latched request fields
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response/write-ack, ≥1 cycle after gnt
- mem_rdata  in  DW  read data, valid with mem_rvalid
- stall_if  out  1  fetch not yet satisfied
- stall_mem  out  1  data access not yet satisfied

## Operation
- States: IDLE, ISSUE, WAIT_RESP. Registers: owner (I/D), drop flag, streak counter (0..MAX_DSTREAK), latched request fields.
- IDLE: select D if d_req && (streak < MAX_DSTREAK || !if_req); otherwise I if if_req && !if_flush; else stay in IDLE. On select: latch fields and owner, go to ISSUE.
- Streak: +1 on each D grant while if_req is high; cleared on any I grant or any cycle with if_req low; saturates at MAX_DSTREAK.
- ISSUE: mem_req=1 with latched fields. On mem_gnt go to WAIT_RESP. Fields are stable and mem_req is never withdrawn before gnt.
- WAIT_RESP: mem_req=0. On mem_rvalid go to IDLE and pulse the owner's valid combinationally; rdata is passed through from mem_rdata.
- Flush: if_flush while owner=I in ISSUE or WAIT_RESP sets drop. The transaction completes, but if_valid is suppressed and drop clears on return to IDLE. Flush in the same cycle as mem_rvalid also suppresses if_valid. Flush in IDLE blocks I selection that cycle only.
- Fetch reads ignore mem_rdata for writes; d_rdata is undefined on store completion.
- stall_if = if_req && !if_valid; stall_mem = d_req && !d_valid (combinational).
- mem_rvalid and mem_gnt in IDLE are ignored (e.g. a stale response after reset).

## Timing
- Reset values: state IDLE, owner I, drop 0, streak 0, mem_req 0, all latched fields 0, if_valid/d_valid 0.
- Reset mid-transaction returns to IDLE immediately; the pending response is dropped.
- Best case: request at cycle n (IDLE), mem_req at n+1 with gnt, rvalid at n+2, valid at n+2. Next arbitration happens at n+3.
- Throughput: ≤1 transaction per 3 cycles. Fetch and data never overlap.
- Simultaneous if_req and d_req: D wins unless streak = MAX_DSTREAK.

## Structure
- Package mem_arb_pkg holds the state enum (IDLE/ISSUE/WAIT_RESP), the owner enum (OWN_I/OWN_D), and the MAX_DSTREAK default.
- Sub-module arb_req_latch: an enable-loaded register for {we, addr, wdata, be} with async reset. The FSM, streak counter and output muxing live in the top module.

## Test plan
- Lone fetch, addr 0x0000_0100, gnt immediate, rvalid one cycle later with 0x0010_0093 → if_valid at cycle 2 with rdata 0x0010_0093; stall_if high cycles 0–1.
- Simultaneous if_req and d_req (load 0x2000) → load issued first. After d_valid, the fetch issues; stall_if stays high throughout the load.
- d_req held continuously with if_req, MAX_DSTREAK=4 → exactly 4 data grants, then 1 fetch grant, then the streak restarts.
- Fetch in WAIT_RESP and if_flush pulsed → mem_rvalid arrives, if_valid stays 0, FSM returns to IDLE, and a new if_addr 0x0000_0200 is fetched next.
- Store 0xDEAD_BEEF, be 4'b0011, addr 0x3000 with gnt delayed 3 cycles → mem fields stable and mem_req high for all 4 cycles; d_valid on rvalid.
- reset asserted in WAIT_RESP, then mem_rvalid arrives → all outputs 0, no valid pulse, state IDLE.
